hazard_fwd_unit: RTL and testbench

//  Parametrised hazard/forwarding tracker for the ASIP pipeline (IF-ID-EX-...-WB).

---
 rtl/hazard_fwd_unit.sv | 87 ++++++++
 tb/tb_hazard_fwd_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_unit.sv
// Tracks in-flight destination registers behind ID, drives operand-forward selects and load-use stalls.
// Selects and stall are combinational from the slot chain; the chain and stall counter update each rising clock.
module hazard_fwd_unit #(
  parameter int REG_BITS = 5,
  parameter int STAGES   = 3,
  parameter int LOAD_LAT = 1,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic [REG_BITS-1:0] issue_rd,
  input  logic                issue_we,
  input  logic                issue_load,
  input  logic [REG_BITS-1:0] id_ra,
  input  logic [REG_BITS-1:0] id_rb,
  input  logic                id_ra_used,
  input  logic                id_rb_used,
  input  logic                flush,
  output logic                stall,
  output logic [2:0]          fwd_a,
  output logic [2:0]          fwd_b,
  output logic [CNT_W-1:0]    stall_count
);

  typedef struct packed {
    logic                vld;
    logic [REG_BITS-1:0] rd;
    logic                we;
    logic                load;
  } slot_t;

  slot_t            r_slot [STAGES];
  logic [CNT_W-1:0] r_stall_count;
  logic [2:0]       w_fwd_a;
  logic [2:0]       w_fwd_b;
  logic             w_ld_a;
  logic             w_ld_b;
  logic             w_stall;

  function automatic logic match(input slot_t s, input logic [REG_BITS-1:0] src);
    return s.vld && s.we && (s.rd == src) && !((ZERO_REG != 0) && (src == '0));
  endfunction

  // Walk oldest to youngest so the youngest producer overwrites earlier hits.
  always_comb begin
    w_fwd_a = '0;
    w_fwd_b = '0;
    w_ld_a  = 1'b0;
    w_ld_b  = 1'b0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (id_ra_used && match(r_slot[i], id_ra)) begin
        w_fwd_a = 3'(i + 1);
        w_ld_a  = r_slot[i].load && (i < LOAD_LAT);
      end
      if (id_rb_used && match(r_slot[i], id_rb)) begin
        w_fwd_b = 3'(i + 1);
        w_ld_b  = r_slot[i].load && (i < LOAD_LAT);
      end
    end
  end

  assign w_stall     = issue_valid && !flush && (w_ld_a || w_ld_b);
  assign stall       = w_stall;
  assign fwd_a       = w_fwd_a;
  assign fwd_b       = w_fwd_b;
  assign stall_count = r_stall_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) r_slot[i] <= '0;
      r_stall_count <= '0;
    end else begin
      // A flush kills the EX entry instead of letting it advance into slot1.
      for (int i = 1; i < STAGES; i++)
        r_slot[i] <= (i == 1 && flush) ? '0 : r_slot[i-1];
      if (issue_valid && !w_stall && !flush)
        r_slot[0] <= '{vld: 1'b1, rd: issue_rd, we: issue_we, load: issue_load};
      else
        r_slot[0] <= '0;
      if (w_stall && (r_stall_count != '1))
        r_stall_count <= r_stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench: main instance (ZERO_REG=1, CNT_W=4) plus a ZERO_REG=0 twin sharing the same inputs.
module tb_hazard_fwd_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic       issue_valid, issue_we, issue_load;
  logic [4:0] issue_rd, id_ra, id_rb;
  logic       id_ra_used, id_rb_used, flush;
  logic       stall, z_stall;
  logic [2:0] fwd_a, fwd_b, z_fwd_a, z_fwd_b;
  logic [3:0] stall_count, z_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  hazard_fwd_unit #(.REG_BITS(5), .STAGES(3), .LOAD_LAT(1), .ZERO_REG(1), .CNT_W(4)) u_dut (
    .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_we(issue_we), .issue_load(issue_load), .id_ra(id_ra), .id_rb(id_rb),
    .id_ra_used(id_ra_used), .id_rb_used(id_rb_used), .flush(flush),
    .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count));

  hazard_fwd_unit #(.REG_BITS(5), .STAGES(3), .LOAD_LAT(1), .ZERO_REG(0), .CNT_W(4)) u_dut_z (
    .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_we(issue_we), .issue_load(issue_load), .id_ra(id_ra), .id_rb(id_rb),
    .id_ra_used(id_ra_used), .id_rb_used(id_rb_used), .flush(flush),
    .stall(z_stall), .fwd_a(z_fwd_a), .fwd_b(z_fwd_b), .stall_count(z_count));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_rd = '0; issue_we = 1'b0; issue_load = 1'b0;
    id_ra = '0; id_rb = '0; id_ra_used = 1'b0; id_rb_used = 1'b0; flush = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic we, input logic ld);
    issue_valid = 1'b1; issue_rd = rd; issue_we = we; issue_load = ld;
  endtask

  task automatic srcs(input logic [4:0] ra, input logic ua, input logic [4:0] rb, input logic ub);
    id_ra = ra; id_ra_used = ua; id_rb = rb; id_rb_used = ub;
  endtask

  task automatic drain();
    idle();
    repeat (4) tick();
  endtask

  initial begin
    // Reset with random inputs
    reset = 1'b0;
    issue_valid = 1'($urandom); issue_rd = 5'($urandom); issue_we = 1'($urandom);
    issue_load = 1'($urandom); id_ra = 5'($urandom); id_rb = 5'($urandom);
    id_ra_used = 1'($urandom); id_rb_used = 1'($urandom); flush = 1'($urandom);
    #3;
    chk("reset_stall", 32'(stall), 0);
    chk("reset_fwd_a", 32'(fwd_a), 0);
    chk("reset_fwd_b", 32'(fwd_b), 0);
    chk("reset_count", 32'(stall_count), 0);
    tick();
    chk("reset_clk_fwd_a", 32'(fwd_a), 0);
    idle();
    #2 reset = 1'b1;
    tick();

    // EX forward and aging out of the chain
    issue(5'd3, 1'b1, 1'b0); srcs(5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    issue(5'd10, 1'b1, 1'b0); srcs(5'd3, 1'b1, 5'd3, 1'b0);
    #1;
    chk("ex_fwd_a1", 32'(fwd_a), 1);
    chk("ex_fwd_b_unused", 32'(fwd_b), 0);
    chk("ex_no_stall", 32'(stall), 0);
    tick();
    issue_valid = 1'b0; #1;
    chk("ex_fwd_a2", 32'(fwd_a), 2);
    tick(); #1;
    chk("ex_fwd_a3", 32'(fwd_a), 3);
    tick(); #1;
    chk("ex_fwd_a_gone", 32'(fwd_a), 0);
    drain();

    // Youngest producer wins
    issue(5'd5, 1'b1, 1'b0); tick();
    issue(5'd5, 1'b1, 1'b0); tick();
    issue_valid = 1'b0; srcs(5'd5, 1'b0, 5'd5, 1'b1); #1;
    chk("young_fwd_b", 32'(fwd_b), 1);
    chk("young_fwd_a_unused", 32'(fwd_a), 0);
    drain();

    // Load-use stall, bubble and counter
    issue(5'd7, 1'b1, 1'b1); tick();
    issue(5'd8, 1'b1, 1'b0); srcs(5'd7, 1'b1, 5'd0, 1'b0); #1;
    chk("lu_stall", 32'(stall), 1);
    chk("lu_fwd_a_during", 32'(fwd_a), 1);
    chk("lu_count0", 32'(stall_count), 0);
    tick();
    chk("lu_stall_clear", 32'(stall), 0);
    chk("lu_fwd_a2", 32'(fwd_a), 2);
    chk("lu_count1", 32'(stall_count), 1);
    srcs(5'd8, 1'b1, 5'd0, 1'b0); #1;
    chk("lu_slot0_bubble", 32'(fwd_a), 0);
    drain();

    // Older load shadowed by a younger ALU write
    issue(5'd9, 1'b1, 1'b1); tick();
    issue(5'd9, 1'b1, 1'b0); tick();
    issue(5'd11, 1'b1, 1'b0); srcs(5'd9, 1'b1, 5'd0, 1'b0); #1;
    chk("shadow_stall", 32'(stall), 0);
    chk("shadow_fwd_a", 32'(fwd_a), 1);
    drain();

    // Zero register
    issue(5'd0, 1'b1, 1'b0); tick();
    issue_valid = 1'b0; srcs(5'd0, 1'b1, 5'd0, 1'b0); #1;
    chk("zero_fwd_a", 32'(fwd_a), 0);
    chk("zero_stall", 32'(stall), 0);
    chk("nozero_fwd_a", 32'(z_fwd_a), 1);
    drain();
    issue(5'd0, 1'b1, 1'b1); tick();
    issue(5'd1, 1'b0, 1'b0); srcs(5'd0, 1'b1, 5'd0, 1'b0); #1;
    chk("zero_load_stall", 32'(stall), 0);
    chk("nozero_load_stall", 32'(z_stall), 1);
    drain();

    // Flush kills ID and EX, older slots shift on
    issue(5'd4, 1'b1, 1'b0); tick();
    issue(5'd2, 1'b1, 1'b1); tick();
    issue(5'd6, 1'b1, 1'b0); srcs(5'd2, 1'b1, 5'd0, 1'b0); flush = 1'b1; #1;
    chk("flush_stall", 32'(stall), 0);
    tick();
    idle(); srcs(5'd2, 1'b1, 5'd4, 1'b1); #1;
    chk("flush_slot1_dead", 32'(fwd_a), 0);
    chk("flush_old_shift", 32'(fwd_b), 3);
    srcs(5'd6, 1'b1, 5'd0, 1'b0); #1;
    chk("flush_slot0_dead", 32'(fwd_a), 0);

    // Alternating load-use: a stall on every odd cycle, counter saturates at 15
    idle(); tick();
    issue(5'd7, 1'b1, 1'b1); srcs(5'd7, 1'b1, 5'd0, 1'b0);
    for (int i = 0; i < 42; i++) begin
      #1;
      chk("sat_stall", 32'(stall), 32'(i % 2));
      chk("sat_count", 32'(stall_count), (1 + i / 2 > 15) ? 15 : 1 + i / 2);
      tick();
    end
    chk("sat_final", 32'(stall_count), 15);

    // Asynchronous reset mid-stall
    tick();
    chk("arst_pre_stall", 32'(stall), 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_stall", 32'(stall), 0);
    chk("arst_count", 32'(stall_count), 0);
    chk("arst_fwd_a", 32'(fwd_a), 0);
    idle();
    #2 reset = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
